// File: rtl/hazard_unit_gen2_if.sv
// Signal bundle between the datapath (master) and hazard_unit_gen2 (slave):
// operand/producer tags and control-flow status in, forwarding selects and stage controls out.
interface hazard_unit_gen2_if #(
    parameter int unsigned AW      = 5,
    parameter int unsigned NUM_FWD = 2
);
    localparam int unsigned FW = $clog2(NUM_FWD + 1);

    logic [AW-1:0]         d_rs1;
    logic [AW-1:0]         d_rs2;
    logic                  d_rs1_used;
    logic                  d_rs2_used;
    logic [AW-1:0]         ex_rs1;
    logic [AW-1:0]         ex_rs2;
    logic                  ex_rs1_used;
    logic                  ex_rs2_used;
    logic [AW-1:0]         ex_rd;
    logic                  ex_we;
    logic                  ex_is_load;
    logic [NUM_FWD*AW-1:0] stg_rd;
    logic [NUM_FWD-1:0]    stg_we;
    logic [NUM_FWD-1:0]    stg_is_load;
    logic                  mc_busy;
    logic                  ex_branch;
    logic                  ex_branch_taken;
    logic                  ex_jump;

    logic [FW-1:0]         fwd_a;
    logic [FW-1:0]         fwd_b;
    logic                  pc_en;
    logic                  f_d_en;
    logic                  d_e_en;
    logic                  d_e_bubble;
    logic                  pc_src;
    logic                  f_d_flush;
    logic                  d_e_flush;
    logic                  wdog_timeout;

    modport master (
        output d_rs1, d_rs2, d_rs1_used, d_rs2_used,
        output ex_rs1, ex_rs2, ex_rs1_used, ex_rs2_used, ex_rd, ex_we, ex_is_load,
        output stg_rd, stg_we, stg_is_load, mc_busy,
        output ex_branch, ex_branch_taken, ex_jump,
        input  fwd_a, fwd_b, pc_en, f_d_en, d_e_en, d_e_bubble,
        input  pc_src, f_d_flush, d_e_flush, wdog_timeout
    );

    modport slave (
        input  d_rs1, d_rs2, d_rs1_used, d_rs2_used,
        input  ex_rs1, ex_rs2, ex_rs1_used, ex_rs2_used, ex_rd, ex_we, ex_is_load,
        input  stg_rd, stg_we, stg_is_load, mc_busy,
        input  ex_branch, ex_branch_taken, ex_jump,
        output fwd_a, fwd_b, pc_en, f_d_en, d_e_en, d_e_bubble,
        output pc_src, f_d_flush, d_e_flush, wdog_timeout
    );
endinterface

// File: rtl/hazard_unit_gen2.sv
// Hazard unit for the deep pipeline: forwarding selects, load-use stalls, multi-cycle freeze
// with watchdog, and multi-stage redirect flush. Optional perf counters: HAZ_PERF_CNT_EN.
module hazard_unit_gen2 #(
    parameter int unsigned AW               = 5,
    parameter int unsigned NUM_FWD          = 2,
    parameter int unsigned LOAD_READY_STAGE = 1,
    parameter int unsigned FETCH_DEPTH      = 1,
    parameter int unsigned WDOG_MAX         = 255
) (
    input logic               clk,
    input logic               rst,
    hazard_unit_gen2_if.slave hz
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       perf_ld_stall,
    output logic [31:0]       perf_freeze,
    output logic [31:0]       perf_redirect
`endif
);
    localparam int unsigned FW  = $clog2(NUM_FWD + 1);
    localparam int unsigned CW  = $clog2(FETCH_DEPTH + 1);
    localparam int unsigned WDW = $clog2(WDOG_MAX + 1);

    typedef enum logic [1:0] {RUN, FREEZE, FLUSH} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;
    logic [WDW-1:0] wdog;
    logic           wdog_to;
    logic           redirect_c;
    logic           flush_mode_c;
    logic           ld_haz_c;

    // Oldest-to-youngest scan so the youngest matching producer overwrites; a not-ready load blocks.
    function automatic logic [FW-1:0] fwd_sel(
        input logic [AW-1:0]         rs,
        input logic                  used,
        input logic [NUM_FWD*AW-1:0] rd,
        input logic [NUM_FWD-1:0]    we,
        input logic [NUM_FWD-1:0]    ld
    );
        logic [FW-1:0] sel;
        sel = '0;
        for (int k = int'(NUM_FWD) - 1; k >= 0; k--) begin
            if (used && rs != '0 && we[k] && rd[k*AW +: AW] == rs)
                sel = (ld[k] && k < int'(LOAD_READY_STAGE)) ? '0 : FW'(k + 1);
        end
        return sel;
    endfunction

    function automatic logic ld_use(
        input logic [AW-1:0]         rs,
        input logic                  used,
        input logic [AW-1:0]         e_rd,
        input logic                  e_we,
        input logic                  e_ld,
        input logic [NUM_FWD*AW-1:0] rd,
        input logic [NUM_FWD-1:0]    we,
        input logic [NUM_FWD-1:0]    ld
    );
        logic hit;
        hit = 1'b0;
        if (used && rs != '0) begin
            if (LOAD_READY_STAGE > 0 && e_we && e_ld && e_rd == rs)
                hit = 1'b1;
            // Producer k reaches stage k+1 by the time the consumer is in EX.
            for (int k = 0; k < int'(NUM_FWD); k++) begin
                if (k + 1 < int'(LOAD_READY_STAGE) && we[k] && ld[k] && rd[k*AW +: AW] == rs)
                    hit = 1'b1;
            end
        end
        return hit;
    endfunction

    assign redirect_c   = (hz.ex_branch & hz.ex_branch_taken) | hz.ex_jump;
    assign flush_mode_c = (state == FLUSH) || (state == FREEZE && cnt != '0);
    assign ld_haz_c     = ld_use(hz.d_rs1, hz.d_rs1_used, hz.ex_rd, hz.ex_we, hz.ex_is_load,
                                 hz.stg_rd, hz.stg_we, hz.stg_is_load)
                        | ld_use(hz.d_rs2, hz.d_rs2_used, hz.ex_rd, hz.ex_we, hz.ex_is_load,
                                 hz.stg_rd, hz.stg_we, hz.stg_is_load);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state and stage controls; mc_busy > redirect > load-use, freeze exit applies same cycle.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        hz.fwd_a      = '0;
        hz.fwd_b      = '0;
        hz.pc_en      = 1'b1;
        hz.f_d_en     = 1'b1;
        hz.d_e_en     = 1'b1;
        hz.d_e_bubble = 1'b0;
        hz.pc_src     = 1'b0;
        hz.f_d_flush  = 1'b0;
        hz.d_e_flush  = 1'b0;
        if (rst) begin
            hz.fwd_a = fwd_sel(hz.ex_rs1, hz.ex_rs1_used, hz.stg_rd, hz.stg_we, hz.stg_is_load);
            hz.fwd_b = fwd_sel(hz.ex_rs2, hz.ex_rs2_used, hz.stg_rd, hz.stg_we, hz.stg_is_load);
            if (hz.mc_busy) begin
                hz.pc_en  = 1'b0;
                hz.f_d_en = 1'b0;
                hz.d_e_en = 1'b0;
                state_nxt = FREEZE;
            end else if (redirect_c) begin
                hz.pc_src    = 1'b1;
                hz.f_d_flush = 1'b1;
                hz.d_e_flush = 1'b1;
                cnt_nxt      = CW'(FETCH_DEPTH - 1);
                state_nxt    = (FETCH_DEPTH > 1) ? FLUSH : RUN;
            end else if (flush_mode_c) begin
                hz.f_d_flush = 1'b1;
                cnt_nxt      = cnt - CW'(1);
                state_nxt    = (cnt == CW'(1)) ? RUN : FLUSH;
            end else begin
                state_nxt = RUN;
                if (ld_haz_c) begin
                    hz.pc_en      = 1'b0;
                    hz.f_d_en     = 1'b0;
                    hz.d_e_en     = 1'b0;
                    hz.d_e_bubble = 1'b1;
                end
            end
        end
    end

    // Watchdog counts consecutive busy cycles; timeout is sticky until reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wdog    <= '0;
            wdog_to <= 1'b0;
        end else if (hz.mc_busy) begin
            if (wdog != WDW'(WDOG_MAX))
                wdog <= wdog + WDW'(1);
            if (wdog >= WDW'(WDOG_MAX - 1))
                wdog_to <= 1'b1;
        end else begin
            wdog <= '0;
        end
    end

    assign hz.wdog_timeout = wdog_to;

`ifdef HAZ_PERF_CNT_EN
    // Saturating event counters; pc_src and d_e_bubble assert exactly on redirect / load-use stall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_ld_stall <= '0;
            perf_freeze   <= '0;
            perf_redirect <= '0;
        end else begin
            if (hz.d_e_bubble && perf_ld_stall != '1)
                perf_ld_stall <= perf_ld_stall + 32'd1;
            if (hz.mc_busy && perf_freeze != '1)
                perf_freeze <= perf_freeze + 32'd1;
            if (hz.pc_src && perf_redirect != '1)
                perf_redirect <= perf_redirect + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_unit_gen2.sv
// Self-checking bench for hazard_unit_gen2: directed scenarios plus randomized traffic
// against a cycle-level reference model (remaining-flush count, consecutive-freeze count).
module tb_hazard_unit_gen2;
    localparam int AW  = 5;
    localparam int NF  = 3;
    localparam int LRS = 2;
    localparam int FD  = 3;
    localparam int WD  = 255;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   st_rd [NF];
    bit   st_we [NF];
    bit   st_ld [NF];

    hazard_unit_gen2_if #(.AW(AW), .NUM_FWD(NF)) hif ();

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] p_ld, p_frz, p_rd;
`endif

    hazard_unit_gen2 #(
        .AW(AW), .NUM_FWD(NF), .LOAD_READY_STAGE(LRS), .FETCH_DEPTH(FD), .WDOG_MAX(WD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz(hif)
`ifdef HAZ_PERF_CNT_EN
        ,
        .perf_ld_stall(p_ld),
        .perf_freeze(p_frz),
        .perf_redirect(p_rd)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stages;
        for (int k = 0; k < NF; k++) begin
            hif.stg_rd[k*AW +: AW] = AW'(st_rd[k]);
            hif.stg_we[k]          = st_we[k];
            hif.stg_is_load[k]     = st_ld[k];
        end
    endtask

    task automatic clear_in;
        hif.d_rs1 = '0; hif.d_rs2 = '0; hif.d_rs1_used = 0; hif.d_rs2_used = 0;
        hif.ex_rs1 = '0; hif.ex_rs2 = '0; hif.ex_rs1_used = 0; hif.ex_rs2_used = 0;
        hif.ex_rd = '0; hif.ex_we = 0; hif.ex_is_load = 0; hif.mc_busy = 0;
        hif.ex_branch = 0; hif.ex_branch_taken = 0; hif.ex_jump = 0;
        for (int k = 0; k < NF; k++) begin
            st_rd[k] = 0; st_we[k] = 0; st_ld[k] = 0;
        end
        apply_stages();
    endtask

    task automatic do_reset;
        rst = 1'b0;
        clear_in();
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Place a load to x7 at pipeline position pos (-1 = EX, k = producer stage k).
    task automatic drive_load(input int pos);
        hif.ex_rd = '0; hif.ex_we = 0; hif.ex_is_load = 0;
        for (int k = 0; k < NF; k++) begin
            st_rd[k] = 0; st_we[k] = 0; st_ld[k] = 0;
        end
        if (pos < 0) begin
            hif.ex_rd = 5'd7; hif.ex_we = 1; hif.ex_is_load = 1;
        end else if (pos < NF) begin
            st_rd[pos] = 7; st_we[pos] = 1; st_ld[pos] = 1;
        end
        apply_stages();
    endtask

    function automatic int exp_fwd(int rs, bit used);
        if (!used || rs == 0) return 0;
        for (int k = 0; k < NF; k++)
            if (st_we[k] && st_rd[k] == rs) return (st_ld[k] && k < LRS) ? 0 : k + 1;
        return 0;
    endfunction

    function automatic bit exp_haz(int rs, bit used);
        if (!used || rs == 0) return 0;
        if (LRS > 0 && hif.ex_we && hif.ex_is_load && int'(hif.ex_rd) == rs) return 1;
        for (int k = 0; k < NF; k++)
            if (k + 1 < LRS && st_we[k] && st_ld[k] && st_rd[k] == rs) return 1;
        return 0;
    endfunction

    task automatic test_reset;
        rst = 1'b0;
        clear_in();
        hif.mc_busy = 1; hif.ex_jump = 1;
        st_rd[0] = 5; st_we[0] = 1; apply_stages();
        hif.ex_rs1 = 5'd5; hif.ex_rs1_used = 1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++;
            if ({hif.pc_en, hif.f_d_en, hif.d_e_en, hif.d_e_bubble, hif.pc_src, hif.f_d_flush,
                 hif.d_e_flush, hif.wdog_timeout} !== 8'b1110_0000 || hif.fwd_a !== 2'd0) begin
                n_bad++;
                $display("FAIL reset_outputs: got ctl=%b fwd_a=%0d expected ctl=11100000 fwd_a=0",
                         {hif.pc_en, hif.f_d_en, hif.d_e_en, hif.d_e_bubble, hif.pc_src,
                          hif.f_d_flush, hif.d_e_flush, hif.wdog_timeout}, hif.fwd_a);
            end
            tick();
        end
        rst = 1'b1; hif.ex_jump = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++;
            if ({hif.pc_en, hif.f_d_en, hif.d_e_en} !== 3'b000 || hif.fwd_a !== 2'd1) begin
                n_bad++;
                $display("FAIL reset_then_freeze: got en=%b fwd_a=%0d expected en=000 fwd_a=1",
                         {hif.pc_en, hif.f_d_en, hif.d_e_en}, hif.fwd_a);
            end
            tick();
        end
        hif.mc_busy = 0;
        #1;
        n_cmp++;
        if (hif.pc_en !== 1'b1) begin
            n_bad++;
            $display("FAIL freeze_exit: got pc_en=%0d expected 1", hif.pc_en);
        end
        tick();
    endtask

    task automatic test_forwarding;
        int exp_a [7] = '{1, 0, 0, 2, 3, 0, 1};
        do_reset();
        hif.ex_rs1_used = 1; hif.ex_rs2_used = 1; hif.ex_rs2 = 5'd9;
        for (int c = 0; c < 7; c++) begin
            case (c)
                0: begin st_rd = '{5, 5, 9}; st_we = '{1, 1, 0}; st_ld = '{0, 0, 0}; hif.ex_rs1 = 5'd5; end
                1: begin st_rd = '{0, 0, 0}; st_we = '{1, 1, 1}; hif.ex_rs1 = 5'd0; end
                2: begin st_rd = '{5, 5, 9}; st_ld = '{1, 0, 0}; hif.ex_rs1 = 5'd5; end
                3: begin st_we = '{0, 1, 1}; end
                4: begin st_rd = '{0, 0, 5}; st_we = '{0, 0, 1}; st_ld = '{0, 0, 1}; end
                5: begin hif.ex_rs1_used = 0; end
                default: begin hif.ex_rs1_used = 1; st_rd = '{5, 5, 5}; st_we = '{1, 1, 1}; st_ld = '{0, 1, 1}; end
            endcase
            apply_stages();
            #1;
            n_cmp++;
            if (int'(hif.fwd_a) !== exp_a[c]) begin
                n_bad++;
                $display("FAIL fwd_a_case%0d: got %0d expected %0d", c, hif.fwd_a, exp_a[c]);
            end
            n_cmp++;
            if (int'(hif.fwd_b) !== exp_fwd(9, 1)) begin
                n_bad++;
                $display("FAIL fwd_b_case%0d: got %0d expected %0d", c, hif.fwd_b, exp_fwd(9, 1));
            end
        end
        tick();
    endtask

    task automatic test_load_use;
        for (int start = -1; start <= 0; start++) begin
            int pos;
            int stalls;
            bit done;
            do_reset();
            pos = start; stalls = 0; done = 0;
            for (int c = 0; c < 8 && !done; c++) begin
                drive_load(pos);
                hif.d_rs1 = 5'd7; hif.d_rs1_used = 1;
                #1;
                if (hif.d_e_bubble) begin
                    stalls++;
                    n_cmp++;
                    if ({hif.pc_en, hif.f_d_en, hif.d_e_en} !== 3'b000) begin
                        n_bad++;
                        $display("FAIL ld_stall_en: got %b expected 000", {hif.pc_en, hif.f_d_en, hif.d_e_en});
                    end
                    tick();
                    pos++;
                end else begin
                    done = 1;
                end
            end
            n_cmp++;
            if (stalls !== LRS - (start + 1)) begin
                n_bad++;
                $display("FAIL ld_stall_len_from%0d: got %0d expected %0d", start, stalls, LRS - (start + 1));
            end
            tick();
            pos++;
            drive_load(pos);
            hif.d_rs1 = '0; hif.d_rs1_used = 0; hif.ex_rs1 = 5'd7; hif.ex_rs1_used = 1;
            #1;
            n_cmp++;
            if (int'(hif.fwd_a) !== LRS + 1) begin
                n_bad++;
                $display("FAIL ld_fwd_after_stall: got %0d expected %0d", hif.fwd_a, LRS + 1);
            end
            tick();
        end
    endtask

    task automatic test_redirect;
        int n_pcs, n_fdf, n_def, n_en;
        do_reset();
        n_pcs = 0; n_fdf = 0; n_def = 0; n_en = 0;
        hif.ex_jump = 1;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_pcs += int'(hif.pc_src); n_fdf += int'(hif.f_d_flush); n_def += int'(hif.d_e_flush);
            n_en += int'(hif.pc_en & hif.f_d_en & hif.d_e_en);
            tick();
            hif.ex_jump = 0;
        end
        n_cmp++;
        if (n_pcs !== 1 || n_fdf !== FD || n_def !== 1 || n_en !== 6) begin
            n_bad++;
            $display("FAIL jump_flush_counts: got pc_src=%0d f_d_flush=%0d d_e_flush=%0d en=%0d expected 1 %0d 1 6",
                     n_pcs, n_fdf, n_def, n_en, FD);
        end
        hif.ex_branch = 1; hif.ex_branch_taken = 0;
        #1;
        n_cmp++;
        if (hif.pc_src !== 1'b0 || hif.f_d_flush !== 1'b0) begin
            n_bad++;
            $display("FAIL branch_not_taken: got pc_src=%0d f_d_flush=%0d expected 0 0", hif.pc_src, hif.f_d_flush);
        end
        hif.ex_branch_taken = 1;
        #1;
        n_cmp++;
        if (hif.pc_src !== 1'b1 || hif.d_e_flush !== 1'b1) begin
            n_bad++;
            $display("FAIL branch_taken: got pc_src=%0d d_e_flush=%0d expected 1 1", hif.pc_src, hif.d_e_flush);
        end
        tick();
        clear_in();
        tick(); tick(); tick();
    endtask

    task automatic test_watchdog;
        do_reset();
        hif.mc_busy = 1;
        for (int k = 0; k <= 300; k++) begin
            #1;
            if (k == 0 || k == 254 || k == 255 || k == 300) begin
                n_cmp++;
                if (hif.wdog_timeout !== (k >= WD) || hif.pc_en !== 1'b0) begin
                    n_bad++;
                    $display("FAIL wdog_after_%0d: got timeout=%0d pc_en=%0d expected %0d 0",
                             k, hif.wdog_timeout, hif.pc_en, k >= WD);
                end
            end
            tick();
        end
        hif.mc_busy = 0;
        tick();
        n_cmp++;
        if (hif.wdog_timeout !== 1'b1 || hif.pc_en !== 1'b1) begin
            n_bad++;
            $display("FAIL wdog_sticky: got timeout=%0d pc_en=%0d expected 1 1", hif.wdog_timeout, hif.pc_en);
        end
    endtask

    task automatic test_redirect_vs_load;
        do_reset();
        drive_load(-1);
        hif.d_rs1 = 5'd7; hif.d_rs1_used = 1; hif.ex_jump = 1;
        #1;
        n_cmp++;
        if (hif.pc_src !== 1'b1 || hif.d_e_bubble !== 1'b0 || hif.pc_en !== 1'b1) begin
            n_bad++;
            $display("FAIL redirect_over_load: got pc_src=%0d bubble=%0d pc_en=%0d expected 1 0 1",
                     hif.pc_src, hif.d_e_bubble, hif.pc_en);
        end
        tick();
        clear_in();
        #1;
        n_cmp++;
        if (hif.f_d_flush !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_cycle1: got %0d expected 1", hif.f_d_flush);
        end
        tick();
        hif.mc_busy = 1;
        #1;
        n_cmp++;
        if (hif.f_d_flush !== 1'b0 || hif.pc_en !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_frozen: got f_d_flush=%0d pc_en=%0d expected 0 0", hif.f_d_flush, hif.pc_en);
        end
        tick(); tick();
        hif.mc_busy = 0;
        #1;
        n_cmp++;
        if (hif.f_d_flush !== 1'b1 || hif.pc_src !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_resumed: got f_d_flush=%0d pc_src=%0d expected 1 0", hif.f_d_flush, hif.pc_src);
        end
        tick();
        n_cmp++;
        if (hif.f_d_flush !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_done: got %0d expected 0", hif.f_d_flush);
        end
    endtask

    task automatic test_random;
        int  fl, frz;
        bit  to;
        do_reset();
        fl = 0; frz = 0; to = 0;
        for (int c = 0; c < 400; c++) begin
            int   ea, eb;
            bit   redir, haz, en, bub, pcs, fdf, def;
            logic [7:0] got, exp;
            rst = ($urandom_range(0, 49) != 0);
            hif.d_rs1 = AW'($urandom_range(0, 3)); hif.d_rs1_used = 1'($urandom_range(0, 1));
            hif.d_rs2 = AW'($urandom_range(0, 3)); hif.d_rs2_used = 1'($urandom_range(0, 1));
            hif.ex_rs1 = AW'($urandom_range(0, 3)); hif.ex_rs1_used = 1'($urandom_range(0, 1));
            hif.ex_rs2 = AW'($urandom_range(0, 3)); hif.ex_rs2_used = 1'($urandom_range(0, 1));
            hif.ex_rd = AW'($urandom_range(0, 3)); hif.ex_we = 1'($urandom_range(0, 1));
            hif.ex_is_load = 1'($urandom_range(0, 1));
            hif.mc_busy = ($urandom_range(0, 99) < 15);
            hif.ex_branch = ($urandom_range(0, 99) < 20);
            hif.ex_branch_taken = 1'($urandom_range(0, 1));
            hif.ex_jump = ($urandom_range(0, 99) < 5);
            for (int k = 0; k < NF; k++) begin
                st_rd[k] = $urandom_range(0, 3);
                st_we[k] = 1'($urandom_range(0, 1));
                st_ld[k] = 1'($urandom_range(0, 1));
            end
            apply_stages();
            redir = (hif.ex_branch & hif.ex_branch_taken) | hif.ex_jump;
            haz = exp_haz(int'(hif.d_rs1), hif.d_rs1_used) | exp_haz(int'(hif.d_rs2), hif.d_rs2_used);
            ea = rst ? exp_fwd(int'(hif.ex_rs1), hif.ex_rs1_used) : 0;
            eb = rst ? exp_fwd(int'(hif.ex_rs2), hif.ex_rs2_used) : 0;
            en = 1; bub = 0; pcs = 0; fdf = 0; def = 0;
            if (rst) begin
                if (hif.mc_busy) en = 0;
                else if (redir) begin pcs = 1; fdf = 1; def = 1; end
                else if (fl > 0) fdf = 1;
                else if (haz) begin en = 0; bub = 1; end
            end
            exp = {en, en, en, bub, pcs, fdf, def, to};
            #1;
            got = {hif.pc_en, hif.f_d_en, hif.d_e_en, hif.d_e_bubble, hif.pc_src, hif.f_d_flush,
                   hif.d_e_flush, hif.wdog_timeout};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL rand_ctl_cyc%0d: got %b expected %b", c, got, exp);
            end
            n_cmp++;
            if (int'(hif.fwd_a) !== ea || int'(hif.fwd_b) !== eb) begin
                n_bad++;
                $display("FAIL rand_fwd_cyc%0d: got %0d/%0d expected %0d/%0d", c, hif.fwd_a, hif.fwd_b, ea, eb);
            end
            tick();
            if (!rst) begin
                fl = 0; frz = 0; to = 0;
            end else if (hif.mc_busy) begin
                frz++;
                if (frz >= WD) to = 1;
            end else begin
                frz = 0;
                if (redir) fl = FD - 1;
                else if (fl > 0) fl--;
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        clear_in();
        test_reset();
        test_forwarding();
        test_load_use();
        test_redirect();
        test_watchdog();
        test_redirect_vs_load();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
